// File: rtl/mem_rr_arbiter_if.sv
// mem_rr_arbiter_if: bundle of every handshake/bus signal around mem_rr_arbiter.
//   slave  modport : the arbiter's own view (takes requester commands and
//                    memory responses, drives grants, memory commands and
//                    routed responses).
//   master modport : the surrounding system's view (requesters + memory).
// Signals:
//   slv_cmd_valid/ready/read_enable/write_enable/addr/data : per-port commands
//   slv_rsp_valid/ready/data                                : per-port responses
//   mst_cmd_valid/ready/read_enable/write_enable/addr/data : arbitrated command
//   mst_rsp_valid/ready/data                                : memory response
//   outstanding, orphan_flag                                : status
interface mem_rr_arbiter_if #(
  parameter int unsigned PORTS           = 2,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
);
  localparam int unsigned WE        = DATA_WIDTH / 8;
  localparam int unsigned CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);

  logic [PORTS-1:0]            slv_cmd_valid;
  logic [PORTS-1:0]            slv_cmd_ready;
  logic [PORTS-1:0]            slv_cmd_read_enable;
  logic [PORTS*WE-1:0]         slv_cmd_write_enable;
  logic [PORTS*ADDR_WIDTH-1:0] slv_cmd_addr;
  logic [PORTS*DATA_WIDTH-1:0] slv_cmd_data;
  logic [PORTS-1:0]            slv_rsp_valid;
  logic [PORTS-1:0]            slv_rsp_ready;
  logic [DATA_WIDTH-1:0]       slv_rsp_data;

  logic                        mst_cmd_valid;
  logic                        mst_cmd_ready;
  logic                        mst_cmd_read_enable;
  logic [WE-1:0]               mst_cmd_write_enable;
  logic [ADDR_WIDTH-1:0]       mst_cmd_addr;
  logic [DATA_WIDTH-1:0]       mst_cmd_data;
  logic                        mst_rsp_valid;
  logic                        mst_rsp_ready;
  logic [DATA_WIDTH-1:0]       mst_rsp_data;

  logic [CNT_WIDTH-1:0]        outstanding;
  logic                        orphan_flag;

  modport slave (
    input  slv_cmd_valid, slv_cmd_read_enable, slv_cmd_write_enable,
           slv_cmd_addr, slv_cmd_data, slv_rsp_ready,
           mst_cmd_ready, mst_rsp_valid, mst_rsp_data,
    output slv_cmd_ready, slv_rsp_valid, slv_rsp_data,
           mst_cmd_valid, mst_cmd_read_enable, mst_cmd_write_enable,
           mst_cmd_addr, mst_cmd_data, mst_rsp_ready,
           outstanding, orphan_flag
  );

  modport master (
    output slv_cmd_valid, slv_cmd_read_enable, slv_cmd_write_enable,
           slv_cmd_addr, slv_cmd_data, slv_rsp_ready,
           mst_cmd_ready, mst_rsp_valid, mst_rsp_data,
    input  slv_cmd_ready, slv_rsp_valid, slv_rsp_data,
           mst_cmd_valid, mst_cmd_read_enable, mst_cmd_write_enable,
           mst_cmd_addr, mst_cmd_data, mst_rsp_ready,
           outstanding, orphan_flag
  );
endinterface

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: PORTS-way round-robin arbiter in front of one memory port.
// Commands pass through a one-entry output register; the index of every
// accepted port is queued in an order FIFO so each memory response (one per
// command, in order) is routed back to the port that issued it.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-low reset
//   bus  : mem_rr_arbiter_if.slave (requester commands/responses, memory
//          command/response, outstanding count, sticky orphan_flag)
// Optional feature: define MEM_RR_ARBITER_PRIORITY0_EN to make port 0 win
// whenever it is valid; the remaining ports then round-robin among themselves.
module mem_rr_arbiter #(
  parameter int unsigned PORTS           = 2,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input logic            clk,
  input logic            rst,
  mem_rr_arbiter_if.slave bus
);
  localparam int unsigned WE = DATA_WIDTH / 8;
  localparam int unsigned PW = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int unsigned FW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  typedef logic [PW-1:0] port_t;

  // Sequential state
  logic                  run;
  port_t                 rr_ptr;
  logic                  out_valid;
  logic                  out_re;
  logic [WE-1:0]         out_we;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [DATA_WIDTH-1:0] out_data;
  port_t                 fifo_mem [MAX_OUTSTANDING];
  logic [FW-1:0]         wr_ptr;
  logic [FW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  orphan;

  // Combinational decode
  logic                  fifo_empty;
  logic                  fifo_full;
  port_t                 head;
  logic                  rsp_pop;
  logic                  gnt_found;
  port_t                 gnt_idx;
  logic                  load_ok;
  logic                  accept;
  logic                  sel_re;
  logic [WE-1:0]         sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(MAX_OUTSTANDING));
  assign head       = fifo_mem[rd_ptr];
  assign rsp_pop    = bus.mst_rsp_valid && !fifo_empty && bus.slv_rsp_ready[head];

  // Search from rr_ptr for the first valid port.
  always_comb begin
    int unsigned cand;
    port_t       cidx;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      cand = 32'(rr_ptr) + i;
      if (cand >= PORTS) cand = cand - PORTS;
      cidx = port_t'(cand);
`ifdef MEM_RR_ARBITER_PRIORITY0_EN
      if (!gnt_found && (cidx != '0) && bus.slv_cmd_valid[cidx]) begin
`else
      if (!gnt_found && bus.slv_cmd_valid[cidx]) begin
`endif
        gnt_found = 1'b1;
        gnt_idx   = cidx;
      end
    end
`ifdef MEM_RR_ARBITER_PRIORITY0_EN
    if (bus.slv_cmd_valid[0]) begin
      gnt_found = 1'b1;
      gnt_idx   = '0;
    end
`endif
  end

  always_comb begin
    sel_re   = 1'b0;
    sel_we   = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned p = 0; p < PORTS; p++) begin
      if (gnt_idx == port_t'(p)) begin
        sel_re   = bus.slv_cmd_read_enable[p];
        sel_we   = bus.slv_cmd_write_enable[p*WE +: WE];
        sel_addr = bus.slv_cmd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = bus.slv_cmd_data[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // A full order FIFO still accepts when a response pops in the same cycle,
  // so the occupancy stays at MAX_OUTSTANDING. run keeps ready low in reset.
  assign load_ok = run && (!out_valid || bus.mst_cmd_ready) && (!fifo_full || rsp_pop);
  assign accept  = gnt_found && load_ok;

  always_comb begin
    bus.slv_cmd_ready          = '0;
    bus.slv_cmd_ready[gnt_idx] = accept;
  end

  always_comb begin
    bus.slv_rsp_valid = '0;
    if (bus.mst_rsp_valid && !fifo_empty) bus.slv_rsp_valid[head] = 1'b1;
    // With nothing outstanding, stray responses are drained.
    bus.mst_rsp_ready = fifo_empty ? 1'b1 : bus.slv_rsp_ready[head];
  end

  assign bus.slv_rsp_data         = bus.mst_rsp_data;
  assign bus.mst_cmd_valid        = out_valid;
  assign bus.mst_cmd_read_enable  = out_re;
  assign bus.mst_cmd_write_enable = out_we;
  assign bus.mst_cmd_addr         = out_addr;
  assign bus.mst_cmd_data         = out_data;
  assign bus.outstanding          = count;
  assign bus.orphan_flag          = orphan;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run       <= 1'b0;
      rr_ptr    <= '0;
      out_valid <= 1'b0;
      out_re    <= 1'b0;
      out_we    <= '0;
      out_addr  <= '0;
      out_data  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      orphan    <= 1'b0;
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) fifo_mem[i] <= '0;
    end else begin
      run <= 1'b1;

      if (accept) begin
        out_valid        <= 1'b1;
        out_re           <= sel_re;
        out_we           <= sel_we;
        out_addr         <= sel_addr;
        out_data         <= sel_data;
        fifo_mem[wr_ptr] <= gnt_idx;
        wr_ptr           <= (wr_ptr == FW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + FW'(1);
`ifdef MEM_RR_ARBITER_PRIORITY0_EN
        if (gnt_idx != '0)
          rr_ptr <= (gnt_idx == port_t'(PORTS - 1)) ? '0 : gnt_idx + port_t'(1);
`else
        rr_ptr <= (gnt_idx == port_t'(PORTS - 1)) ? '0 : gnt_idx + port_t'(1);
`endif
      end else if (bus.mst_cmd_ready) begin
        out_valid <= 1'b0;
      end

      if (rsp_pop)
        rd_ptr <= (rd_ptr == FW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + FW'(1);

      if (accept && !rsp_pop)      count <= count + CW'(1);
      else if (!accept && rsp_pop) count <= count - CW'(1);

      if (bus.mst_rsp_valid && fifo_empty) orphan <= 1'b1;
    end
  end
endmodule
